// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch and length decode.
// Pulls opcode and immediate bytes from a byte-wide memory at eip, packs them
// into ope / immidiate_data, and holds the result until the execution side
// takes it. eip_load redirects fetch (call / ret) from any state.
// Optional build macro: INST_FETCH_ILLEGAL_TRAP_EN (trap unknown opcodes in HALT).
//
// Handshakes:
//   memory : mem_rd is held high with mem_addr stable until a rising edge
//            sees mem_valid=1; that edge takes mem_data. mem_valid is ignored
//            while mem_rd=0 and in any cycle that also carries eip_load.
//   issue  : ope_valid stays high with every instruction output frozen until
//            a rising edge sees ope_valid & ope_ready; only redirect or reset
//            may drop ope_valid without that transfer.
module inst_fetch #(
    parameter logic [31:0] RESET_EIP = 32'h0
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_data,
    input  logic        mem_valid,
    output logic [31:0] ope,
    output logic [31:0] immidiate_data,
    output logic [2:0]  inst_len,
    output logic [31:0] eip_next,
    output logic        ope_valid,
    input  logic        ope_ready,
    input  logic        eip_load,
    input  logic [31:0] eip_in,
    output logic        illegal_op,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        FETCH_OP  = 2'd0,
        FETCH_IMM = 2'd1,
        ISSUE     = 2'd2,
        HALT      = 2'd3
    } state_t;

    state_t      state, state_nx;
    logic [31:0] eip;
    logic [2:0]  k;          // index of the next immediate byte (1..4)
    logic        take;       // a memory byte is captured on this edge
    logic [2:0]  op_len;     // decoded length of mem_data, 0 = unknown opcode
    logic        last_imm;

    // Decoded opcode length; 0 flags an opcode outside the known set.
    function automatic logic [2:0] decode_len(input logic [7:0] op);
        case (op)
            8'h55, 8'h5d, 8'hc3: decode_len = 3'd1;
            8'h89:               decode_len = 3'd2;
            8'hb8, 8'he8:        decode_len = 3'd5;
            default:             decode_len = 3'd0;
        endcase
    endfunction

    assign mem_rd    = (state == FETCH_OP) || (state == FETCH_IMM);
    assign ope_valid = (state == ISSUE);
    assign mem_addr  = eip;
    assign state_dbg = state;
    assign take      = mem_rd && mem_valid && !eip_load;
    assign op_len    = decode_len(mem_data);
    assign last_imm  = (k == (inst_len - 3'd1));

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= FETCH_OP;
        else          state <= state_nx;
    end

    // Next-state logic; a redirect overrides every other transition.
    always_comb begin
        state_nx = state;
        case (state)
            FETCH_OP: begin
                if (take) begin
                    if (op_len == 3'd0) begin
`ifdef INST_FETCH_ILLEGAL_TRAP_EN
                        state_nx = HALT;
`else
                        state_nx = ISSUE;
`endif
                    end else if (op_len == 3'd1) begin
                        state_nx = ISSUE;
                    end else begin
                        state_nx = FETCH_IMM;
                    end
                end
            end
            FETCH_IMM: if (take && last_imm) state_nx = ISSUE;
            ISSUE:     if (ope_ready) state_nx = FETCH_OP;
            HALT:      state_nx = HALT;
            default:   state_nx = FETCH_OP;
        endcase
        if (eip_load) state_nx = FETCH_OP;
    end

    // Fetch pointer and instruction packing; outputs only move on a captured byte.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            eip            <= RESET_EIP;
            ope            <= 32'h0;
            immidiate_data <= 32'h0;
            inst_len       <= 3'd0;
            eip_next       <= 32'h0;
            k              <= 3'd0;
        end else if (eip_load) begin
            eip <= eip_in;
            k   <= 3'd0;
        end else if (take) begin
            eip      <= eip + 32'd1;
            // After the final byte this is opcode address + length.
            eip_next <= eip + 32'd1;
            if (state == FETCH_OP) begin
                ope            <= {mem_data, 24'h0};
                immidiate_data <= 32'h0;
                inst_len       <= (op_len == 3'd0) ? 3'd1 : op_len;
                k              <= 3'd1;
            end else begin
                case (k)
                    3'd1: begin
                        ope[23:16]          <= mem_data;
                        immidiate_data[7:0] <= mem_data;
                    end
                    3'd2: begin
                        ope[15:8]            <= mem_data;
                        immidiate_data[15:8] <= mem_data;
                    end
                    3'd3: begin
                        ope[7:0]              <= mem_data;
                        immidiate_data[23:16] <= mem_data;
                    end
                    3'd4:    immidiate_data[31:24] <= mem_data;
                    default: ;
                endcase
                k <= k + 3'd1;
            end
        end
    end

`ifdef INST_FETCH_ILLEGAL_TRAP_EN
    logic illegal_q;

    // Trap flag: set by an unknown opcode, cleared only by redirect or reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            illegal_q <= 1'b0;
        else if (eip_load)
            illegal_q <= 1'b0;
        else if (take && (state == FETCH_OP) && (op_len == 3'd0))
            illegal_q <= 1'b1;
    end

    assign illegal_op = illegal_q;
`else
    assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: self-checking bench for inst_fetch.
// Directed test-plan sequences, a vector table of single instructions, and a
// randomized instruction stream with random memory waits and back-pressure
// checked against a byte-level model of the instruction format.
module tb_inst_fetch;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data = 8'h0;
    logic        mem_valid = 1'b0;
    logic [31:0] ope;
    logic [31:0] immidiate_data;
    logic [2:0]  inst_len;
    logic [31:0] eip_next;
    logic        ope_valid;
    logic        ope_ready = 1'b0;
    logic        eip_load = 1'b0;
    logic [31:0] eip_in = 32'h0;
    logic        illegal_op;
    logic [1:0]  state_dbg;

    int vec_cnt = 0;
    int err_cnt = 0;

    bit [7:0] mem [256];
    logic [98:0] exp_q[$];

    typedef struct packed {
        logic [39:0] bytes;
        logic [31:0] ope;
        logic [31:0] imm;
        logic [2:0]  len;
    } vec_t;

    vec_t vecs [7];

    inst_fetch #(.RESET_EIP(32'h0)) dut (
        .clock(clock), .reset_n(reset_n),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data), .mem_valid(mem_valid),
        .ope(ope), .immidiate_data(immidiate_data), .inst_len(inst_len), .eip_next(eip_next),
        .ope_valid(ope_valid), .ope_ready(ope_ready),
        .eip_load(eip_load), .eip_in(eip_in),
        .illegal_op(illegal_op), .state_dbg(state_dbg)
    );

    // Clock and reset
    always #5 clock = ~clock;

    task automatic do_reset();
        reset_n = 1'b0;
        mem_valid = 1'b0;
        ope_ready = 1'b0;
        eip_load = 1'b0;
        eip_in = 32'h0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Driver: apply inputs for the coming edge, return 1 time unit after it.
    task automatic step(input logic v, input logic r, input logic l, input logic [31:0] a);
        mem_valid = v;
        mem_data  = mem[mem_addr[7:0]];
        ope_ready = r;
        eip_load  = l;
        eip_in    = a;
        @(posedge clock);
        #1;
    endtask

    // Scoreboard comparison
    task automatic chk(input string name, input logic [98:0] act, input logic [98:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Zero-wait fetch until ope_valid, bounded.
    task automatic wait_issue(input string name);
        int n;
        n = 0;
        while (!ope_valid && n < 12) begin
            step(mem_rd, 1'b0, 1'b0, 32'h0);
            n++;
        end
        if (!ope_valid) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL %s: timeout waiting for ope_valid, got 0 expected 1", name);
        end
    endtask

    // Reference model: length from the opcode table.
    function automatic logic [2:0] model_len(input logic [7:0] op);
        if (op == 8'h55 || op == 8'h5d || op == 8'hc3) return 3'd1;
        if (op == 8'h89) return 3'd2;
        if (op == 8'hb8 || op == 8'he8) return 3'd5;
        return 3'd1;
    endfunction

    // Reference model: whole instruction at address a, packed {ope, imm, len, eip_next}.
    function automatic logic [98:0] model_inst(input logic [31:0] a);
        logic [7:0]  b [5];
        logic [2:0]  len;
        logic [31:0] o, im;
        for (int j = 0; j < 5; j++) b[j] = mem[8'(a + 32'(j))];
        len = model_len(b[0]);
        o = 32'h0;
        im = 32'h0;
        for (int j = 0; j < 4; j++)
            if (j < int'(len)) o = o | (32'(b[j]) << (24 - 8 * j));
        for (int j = 1; j < 5; j++)
            if (j < int'(len)) im = im | (32'(b[j]) << (8 * (j - 1)));
        return {o, im, len, a + 32'(len)};
    endfunction

    initial begin
        logic [31:0] t1_ope [3];
        logic [31:0] t1_imm [3];
        logic [2:0]  t1_len [3];
        logic [31:0] t1_nx  [3];
        int idx;
        logic [7:0] ops [6];

        vecs[0] = '{40'h5500000000, 32'h55000000, 32'h00000000, 3'd1};
        vecs[1] = '{40'h5d00000000, 32'h5d000000, 32'h00000000, 3'd1};
        vecs[2] = '{40'hc300000000, 32'hc3000000, 32'h00000000, 3'd1};
        vecs[3] = '{40'h89e5000000, 32'h89e50000, 32'h000000e5, 3'd2};
        vecs[4] = '{40'hb834120000, 32'hb8341200, 32'h00001234, 3'd5};
        vecs[5] = '{40'he878563412, 32'he8785634, 32'h12345678, 3'd5};
        vecs[6] = '{40'hb8ffffffff, 32'hb8ffffff, 32'hffffffff, 3'd5};

        // ---- Test 1: reset values and the basic zero-wait program ----
        mem[0] = 8'h55; mem[1] = 8'h89; mem[2] = 8'he5; mem[3] = 8'hb8;
        mem[4] = 8'h34; mem[5] = 8'h12; mem[6] = 8'h00; mem[7] = 8'h00;
        do_reset();
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_rd", mem_rd, 1'b1);
        chk("rst_ope", ope, 32'h0);
        chk("rst_imm", immidiate_data, 32'h0);
        chk("rst_len", inst_len, 3'd0);
        chk("rst_eip_next", eip_next, 32'h0);
        chk("rst_ope_valid", ope_valid, 1'b0);
        chk("rst_illegal", illegal_op, 1'b0);

        t1_ope = '{32'h55000000, 32'h89e50000, 32'hb8341200};
        t1_imm = '{32'h0, 32'h000000e5, 32'h00001234};
        t1_len = '{3'd1, 3'd2, 3'd5};
        t1_nx  = '{32'd1, 32'd3, 32'd8};
        idx = 0;
        for (int n = 1; n <= 11; n++) begin
            step(mem_rd, 1'b1, 1'b0, 32'h0);
            chk("t1_valid_pulse", ope_valid, (n == 1 || n == 4 || n == 10));
            if (ope_valid && idx < 3) begin
                chk("t1_ope", ope, t1_ope[idx]);
                chk("t1_imm", immidiate_data, t1_imm[idx]);
                chk("t1_len", inst_len, t1_len[idx]);
                chk("t1_eip_next", eip_next, t1_nx[idx]);
                idx++;
            end
        end

        // ---- Test 2: b8 with 3 wait cycles per byte, then 5 cycles of back-pressure ----
        mem[8'h10] = 8'hb8; mem[8'h11] = 8'haa; mem[8'h12] = 8'hbb;
        mem[8'h13] = 8'hcc; mem[8'h14] = 8'hdd;
        step(1'b0, 1'b0, 1'b1, 32'h10);
        for (int i = 0; i < 5; i++) begin
            for (int w = 0; w < 3; w++) begin
                chk("t2_wait_addr", mem_addr, 32'h10 + 32'(i));
                chk("t2_wait_rd", mem_rd, 1'b1);
                step(1'b0, 1'b0, 1'b0, 32'h0);
            end
            chk("t2_take_addr", mem_addr, 32'h10 + 32'(i));
            step(1'b1, 1'b0, 1'b0, 32'h0);
        end
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid", ope_valid, 1'b1);
            chk("t2_hold_ope", ope, 32'hb8aabbcc);
            chk("t2_hold_imm", immidiate_data, 32'hddccbbaa);
            step(1'b0, 1'b0, 1'b0, 32'h0);
        end
        chk("t2_pre_hs_valid", ope_valid, 1'b1);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("t2_single_hs", ope_valid, 1'b0);
            chk("t2_next_addr", mem_addr, 32'h15);
            step(1'b0, 1'b1, 1'b0, 32'h0);
        end

        // ---- Test 3: redirect mid e8 fetch, without and with a coinciding byte ----
        mem[8'h20] = 8'he8; mem[8'h21] = 8'h11; mem[8'h22] = 8'h22;
        mem[8'h23] = 8'h33; mem[8'h24] = 8'h44; mem[8'h40] = 8'h55;
        for (int c = 0; c < 2; c++) begin
            step(1'b0, 1'b0, 1'b1, 32'h20);
            step(1'b1, 1'b1, 1'b0, 32'h0);
            step(1'b1, 1'b1, 1'b0, 32'h0);
            chk("t3_pending_addr", mem_addr, 32'h22);
            step(c == 1, 1'b1, 1'b1, 32'h40);
            chk("t3_redir_addr", mem_addr, 32'h40);
            chk("t3_no_partial", ope_valid, 1'b0);
            step(1'b1, 1'b0, 1'b0, 32'h0);
            chk("t3_valid", ope_valid, 1'b1);
            chk("t3_ope", ope, 32'h55000000);
            chk("t3_imm", immidiate_data, 32'h0);
            chk("t3_eip_next", eip_next, 32'h41);
            step(1'b0, 1'b1, 1'b0, 32'h0);
        end

        // ---- Test 4: eip wrap from FFFFFFFF to 0 ----
        mem[8'hff] = 8'h89; mem[8'h00] = 8'he5;
        step(1'b0, 1'b0, 1'b1, 32'hffffffff);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("t4_wrap_addr", mem_addr, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("t4_ope", ope, 32'h89e50000);
        chk("t4_eip_next", eip_next, 32'h1);
        chk("t4_mem_addr", mem_addr, 32'h1);
        step(1'b0, 1'b1, 1'b0, 32'h0);

        // ---- Test 5: unknown opcode 0f ----
        mem[8'h30] = 8'h0f; mem[8'h31] = 8'h55;
        step(1'b0, 1'b0, 1'b1, 32'h30);
        step(1'b1, 1'b0, 1'b0, 32'h0);
`ifdef INST_FETCH_ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            chk("t5_illegal", illegal_op, 1'b1);
            chk("t5_halt_rd", mem_rd, 1'b0);
            chk("t5_halt_valid", ope_valid, 1'b0);
            chk("t5_bad_op", ope[31:24], 8'h0f);
            step(1'b1, 1'b1, 1'b0, 32'h0);
        end
        step(1'b0, 1'b0, 1'b1, 32'h31);
        chk("t5_cleared", illegal_op, 1'b0);
        chk("t5_resume_rd", mem_rd, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("t5_resume_ope", ope, 32'h55000000);
`else
        chk("t5_valid", ope_valid, 1'b1);
        chk("t5_ope", ope, 32'h0f000000);
        chk("t5_len", inst_len, 3'd1);
        chk("t5_no_trap", illegal_op, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("t5_next_ope", ope, 32'h55000000);
`endif

        // ---- Test 6: asynchronous reset while in ISSUE ----
        chk("t6_in_issue", ope_valid, 1'b1);
        mem[8'h00] = 8'h55;
        mem_valid = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("t6_async_valid", ope_valid, 1'b0);
        chk("t6_async_addr", mem_addr, 32'h0);
        chk("t6_async_rd", mem_rd, 1'b1);
        chk("t6_async_ope", ope, 32'h0);
        chk("t6_async_imm", immidiate_data, 32'h0);
        chk("t6_async_len", inst_len, 3'd0);
        chk("t6_async_nx", eip_next, 32'h0);
        @(posedge clock);
        #1;
        chk("t6_no_capture", mem_addr, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("t6_restart_ope", ope, 32'h55000000);
        chk("t6_restart_nx", eip_next, 32'h1);
        step(1'b0, 1'b1, 1'b0, 32'h0);

        // ---- Vector table: single instructions at 0x80 ----
        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < 5; j++) mem[8'h80 + j] = vecs[i].bytes[39 - 8 * j -: 8];
            step(1'b0, 1'b0, 1'b1, 32'h80);
            wait_issue("vec_timeout");
            chk("vec_ope", ope, vecs[i].ope);
            chk("vec_imm", immidiate_data, vecs[i].imm);
            chk("vec_len", inst_len, vecs[i].len);
            chk("vec_eip_next", eip_next, 32'h80 + 32'(vecs[i].len));
            step(1'b0, 1'b1, 1'b0, 32'h0);
            chk("vec_accepted", ope_valid, 1'b0);
        end

        // ---- Randomized stream with waits and back-pressure ----
        ops = '{8'h55, 8'h5d, 8'hc3, 8'h89, 8'hb8, 8'he8};
        begin
            int a;
            a = 0;
            while (a < 200) begin
                logic [7:0] op;
                op = ops[$urandom_range(0, 5)];
                mem[a] = op;
                for (int j = 1; j < int'(model_len(op)); j++) mem[a + j] = 8'($urandom);
                a += int'(model_len(op));
            end
            for (int j = a; j < 256; j++) mem[j] = 8'h55;
        end
        begin
            logic [31:0] pa;
            pa = 32'h0;
            for (int n = 0; n < 30; n++) begin
                logic [98:0] e;
                e = model_inst(pa);
                exp_q.push_back(e);
                pa = e[31:0];
            end
        end
        do_reset();
        begin
            int cyc;
            logic v, r, prev_hold, prev_wait;
            logic [31:0] prev_addr, prev_ope;
            logic [98:0] e;
            cyc = 0;
            prev_hold = 1'b0;
            prev_wait = 1'b0;
            prev_addr = 32'h0;
            prev_ope = 32'h0;
            while (exp_q.size() > 0 && cyc < 3000) begin
                if (prev_hold) begin
                    chk("rand_hold_valid", ope_valid, 1'b1);
                    chk("rand_hold_ope", ope, prev_ope);
                end
                if (prev_wait) chk("rand_wait_addr", mem_addr, prev_addr);
                v = ($urandom_range(0, 9) < 7);
                r = ($urandom_range(0, 9) < 6);
                if (ope_valid && r) begin
                    e = exp_q.pop_front();
                    chk("rand_issue", {ope, immidiate_data, inst_len, eip_next}, e);
                end
                prev_hold = ope_valid && !r;
                prev_ope  = ope;
                prev_wait = mem_rd && !v;
                prev_addr = mem_addr;
                step(v, r, 1'b0, 32'h0);
                cyc++;
            end
            if (exp_q.size() != 0) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL rand_timeout: %0d instructions outstanding, expected 0", exp_q.size());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch and length-decode unit for the CPU core. Reads instruction bytes from byte-wide memory at `eip` and packs them into the `ope` / `immidiate_data` words that the ALU and register stages decode. Holds each packed instruction with a valid/ready handshake until the execution side accepts it. Accepts an `eip` redirect for `call` and `ret`.

## Interface
- `RESET_EIP`, default 32'h0: `eip` value loaded on reset.
- `clock`, input, 1: sole clock, rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `mem_addr`, output, 32: byte address being fetched; always equals `eip`.
- `mem_rd`, output, 1: fetch request, held high until `mem_valid`.
- `mem_data`, input, 8: returned byte.
- `mem_valid`, input, 1: `mem_data` valid. Sampled on the rising edge only while `mem_rd`=1.
- `ope`, output, 32: packed instruction (see Operation).
- `immidiate_data`, output, 32: little-endian immediate.
- `inst_len`, output, 3: byte length of the current `ope` (1, 2 or 5).
- `eip_next`, output, 32: address of the byte after the current instruction (return address for `call`).
- `ope_valid`, output, 1: `ope` is presented.
- `ope_ready`, input, 1: execution side accepts `ope`.
- `eip_load`, input, 1: redirect strobe.
- `eip_in`, input, 32: redirect target.
- `illegal_op`, output, 1: unknown opcode trapped.

## Operation
- States: `FETCH_OP`, `FETCH_IMM`, `ISSUE`, `HALT`. Reset state is `FETCH_OP`.
- `FETCH_OP`
  - `mem_rd`=1.
  - On `mem_valid`: opcode goes to `ope[31:24]`, lower `ope` bytes and `immidiate_data` are cleared, `eip`+1.
  - Length decode: 55, 5d, c3 → 1; 89 → 2; b8, e8 → 5.
  - Length 1 → `ISSUE`; otherwise → `FETCH_IMM` with byte counter k=1.
- `FETCH_IMM`
  - Each `mem_valid` stores byte k and increments `eip`.
  - Byte k=1,2,3 goes into `ope[23:16]`, `ope[15:8]`, `ope[7:0]` respectively.
  - Byte k also goes into `immidiate_data[8k-1:8k-8]` for k=1..4.
  - After byte `inst_len`-1 → `ISSUE`.
- `ISSUE`
  - `ope_valid`=1 and `mem_rd`=0.
  - `ope`, `immidiate_data`, `inst_len` and `eip_next` are stable.
  - On `ope_valid`&`ope_ready` → `FETCH_OP`.
- `eip_next` = address of the opcode + `inst_len` = `eip` while in `ISSUE`.
- Arithmetic: `eip` is 32-bit and wraps from 32'hFFFFFFFF to 0.
- Redirect: `eip_load` in any state sets `eip`=`eip_in`, discards any partial or held instruction, clears `illegal_op`, and goes to `FETCH_OP`.
  - A `mem_valid` in the same cycle as `eip_load` is discarded.
  - `eip_load` together with `ope_valid`&`ope_ready`: the handshake counts as accepted, and the redirect applies.
  - `eip_load` in `ISSUE` without `ope_ready`: the instruction is dropped and `ope_valid` falls on the next edge.
- Reset mid-operation: all state returns to reset values immediately and asynchronously. A pending memory byte is never captured.

## Timing
- Reset values:
  - `eip`=`RESET_EIP`, so `mem_addr`=`RESET_EIP`.
  - `mem_rd`=1, since the state is `FETCH_OP`.
  - `ope`=0, `immidiate_data`=0, `inst_len`=0, `eip_next`=0, `ope_valid`=0, `illegal_op`=0.
- With zero-wait memory (`mem_valid`=1 whenever `mem_rd`=1), an N-byte instruction spends N cycles fetching. `ope_valid` rises on the edge that captures the last byte.
- Back-to-back throughput with `ope_ready` held high is N+1 cycles per instruction.
- Each memory wait cycle adds one cycle. `mem_addr` is constant while `mem_rd`=1 and no `mem_valid` has been taken.
- `ope_valid` stays high with all outputs frozen until `ope_ready`. `ope_valid` never falls without a handshake, except on redirect or reset.

## Configuration
- Macro: `INST_FETCH_ILLEGAL_TRAP_EN`.
- Defined: an opcode outside {55, 89, b8, 5d, c3, e8} moves the block to `HALT`.
  - `HALT` holds `illegal_op`=1, `mem_rd`=0 and `ope_valid`=0.
  - `ope[31:24]` holds the bad opcode.
  - `HALT` is left only by `eip_load` or reset.
- Undefined: an unknown opcode is treated as length 1 and issued normally. `illegal_op` is tied to 0.

## Test plan
- Memory 55 89 e5 b8 34 12 00 00 at 0, zero-wait, `ope_ready`=1:
  - `ope` sequence 55000000, 89e50000, b8341200.
  - `immidiate_data` for b8 = 00001234; `inst_len` sequence 1, 2, 5; `eip_next` sequence 1, 3, 8.
  - `ope_valid` pulses at cycles 1, 4, 10.
- b8 fetch with 3 wait cycles per byte, then `ope_ready`=0 for 5 cycles: `mem_addr` is stable during waits; `ope` stays b8xxxxxx with `ope_valid`=1 for all 5 cycles; exactly one handshake occurs.
- `eip_load`=1 with `eip_in`=32'h40 while in the middle of an e8 fetch (byte 2 pending):
  - The next `mem_addr` is 40 and no partial `ope_valid` is seen.
  - If byte 2's `mem_valid` coincides with `eip_load`, it is ignored.
- Wrap-around: `RESET_EIP`=32'hFFFFFFFF with memory 89 at FFFFFFFF and e5 at 0 → `ope`=89e50000 and `eip_next`=1.
- Opcode 0f with the macro defined → `illegal_op`=1, `mem_rd`=0, state held; then `eip_load` to 0 → `illegal_op`=0 and fetching resumes. With the macro undefined → `ope`=0f000000 is issued with `inst_len`=1.
- Assert `reset_n`=0 in the middle of `ISSUE` → `ope_valid` goes to 0 asynchronously, all outputs take reset values, and after release fetching starts at `RESET_EIP`.
